debug_reg_snapshot: RTL

DEBUG_REG_SNAPSHOT -- requirements
Module: debug_reg_snapshot

---
 rtl/debug_snap_pkg.sv | 14 +
 rtl/debug_snap_bank.sv | 72 +++++++
 rtl/debug_reg_snapshot.sv | 112 +++++++++++
 3 files changed

// File: rtl/debug_snap_pkg.sv
// Shared types and default sizing for the debug register snapshot block.
package debug_snap_pkg;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } snap_state_t;

endpackage

// File: rtl/debug_snap_bank.sv
// Double-buffered register storage: the scan fills the back bank while the
// screen reads the front bank, and a swap exchanges their roles atomically.
module debug_snap_bank #(
    parameter int REG_NUM = debug_snap_pkg::REG_NUM,
    parameter int ADDR_W  = debug_snap_pkg::ADDR_W,
    parameter int DATA_W  = debug_snap_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    import debug_snap_pkg::*;

    localparam bit FULL_MAP = (REG_NUM >= (1 << ADDR_W));

    logic              front_sel;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [DATA_W-1:0] bank0 [REG_NUM];
    logic [DATA_W-1:0] bank1 [REG_NUM];

    // Addresses beyond the populated registers only need a guard when the
    // address space is larger than the register count.
    generate
        if (FULL_MAP) begin : g_full_map
            assign rd_in_range = 1'b1;
            assign wr_in_range = 1'b1;
        end else begin : g_part_map
            assign rd_in_range = (rd_addr < ADDR_W'(REG_NUM));
            assign wr_in_range = (wr_addr < ADDR_W'(REG_NUM));
        end
    endgenerate

    // Front-bank select: 0 means bank0 is visible to the screen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel <= 1'b0;
        end else if (swap) begin
            front_sel <= ~front_sel;
        end
    end

    // Scan writes always land in whichever bank is currently hidden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            if (front_sel) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    // Screen read port returns the visible bank, zero for unpopulated addresses.
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = front_sel ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule

// File: rtl/debug_reg_snapshot.sv
// Captures a coherent snapshot of the CPU register file once per debug-screen
// frame. A scan walks every register address, pipelines each word with its
// address by one cycle, and swaps banks only after the last word is stored so
// the screen never sees a half-updated frame.
module debug_reg_snapshot #(
    parameter int REG_NUM = debug_snap_pkg::REG_NUM,
    parameter int ADDR_W  = debug_snap_pkg::ADDR_W,
    parameter int DATA_W  = debug_snap_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              freeze,
    output logic [ADDR_W-1:0] cpu_regAddr,
    input  logic [DATA_W-1:0] cpu_regData,
    input  logic [ADDR_W-1:0] regAddr,
    output logic [DATA_W-1:0] regData,
    output logic              busy,
    output logic [7:0]        snap_cnt
);
    import debug_snap_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);

    snap_state_t       state;
    logic              vsync_d;
    logic              vsync_rise;
    logic              cap_valid;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              swap;

    assign vsync_rise = vsync & ~vsync_d;

    // The bank flips on the same edge that leaves DRAIN, together with the
    // final write, so the last word lands in the bank that becomes visible.
    assign swap = (state == DRAIN);

    // Edge detector for the frame sync; tracks vsync in every state so edges
    // seen while busy are simply dropped rather than remembered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync;
        end
    end

    // Scan sequencer: walks cpu_regAddr, captures each word with its address,
    // and counts completed snapshots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cpu_regAddr <= '0;
            busy        <= 1'b0;
            snap_cnt    <= 8'd0;
            cap_valid   <= 1'b0;
            cap_addr    <= '0;
            cap_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cap_valid   <= 1'b0;
                    cpu_regAddr <= '0;
                    if (vsync_rise && !freeze) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    cap_valid <= 1'b1;
                    cap_addr  <= cpu_regAddr;
                    cap_data  <= cpu_regData;
                    if (cpu_regAddr == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        cpu_regAddr <= cpu_regAddr + 1'b1;
                    end
                end
                DRAIN: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    cap_valid   <= 1'b0;
                    cpu_regAddr <= '0;
                    snap_cnt    <= snap_cnt + 8'd1;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    cap_valid   <= 1'b0;
                    cpu_regAddr <= '0;
                end
            endcase
        end
    end

    debug_snap_bank #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_valid),
        .wr_addr (cap_addr),
        .wr_data (cap_data),
        .swap    (swap),
        .rd_addr (regAddr),
        .rd_data (regData)
    );

endmodule
